// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared mode constants and load clamp helper for updown_counter
package updown_counter_pkg;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // Values at or beyond the modulus collapse to the top of the count range.
   function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                              input logic [31:0] modulus);
      return (val >= modulus) ? (modulus - 32'd1) : val;
   endfunction

endpackage

// File: rtl/updown_counter_tick_gen.sv
// rtl/updown_counter_tick_gen.sv - enable prescaler producing one tick every PRESCALE enabled cycles
module tick_gen #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

   // clr (a load) suppresses the tick so a load cycle never also steps.
   assign tick = en & ~clr & (cnt == LAST);

endmodule

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - prescaled up/down modulo counter with wrap or saturate at range ends
module updown_counter
   import updown_counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = 0,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             sat
);

   generate
      if (MODULUS < 1 || longint'(MODULUS) > (longint'(1) << WIDTH) || PRESCALE < 1) begin : g_bad_params
         $error("updown_counter: illegal MODULUS/PRESCALE for WIDTH");
      end
   endgenerate

   localparam logic [WIDTH:0] TOP   = (WIDTH + 1)'(MODULUS - 1);
   localparam logic [31:0]    MOD32 = 32'(MODULUS);
   localparam logic           HOLD  = (SATURATE == MODE_SAT);

   logic             step;
   logic [WIDTH:0]   q_ext;
   logic [WIDTH:0]   q_inc;
   logic [WIDTH:0]   q_dec;
   logic             at_top;
   logic             at_bot;
   logic [31:0]      load_clamped;
   logic             unused_clamp_hi;

   tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (load),
      .tick  (step)
   );

   assign q_ext           = {1'b0, q};
   assign q_inc           = q_ext + (WIDTH + 1)'(1);
   assign q_dec           = q_ext - (WIDTH + 1)'(1);
   assign at_top          = (q_ext == TOP);
   assign at_bot          = (q_ext == '0);
   assign load_clamped    = clamp_load(32'(load_val), MOD32);
   assign unused_clamp_hi = ^load_clamped[31:WIDTH];

   assign tc = up ? at_top : at_bot;

   always_ff @(posedge clk) begin
      if (reset) begin
         q    <= '0;
         wrap <= 1'b0;
         sat  <= 1'b0;
      end else if (load) begin
         q    <= load_clamped[WIDTH-1:0];
         wrap <= 1'b0;
         sat  <= 1'b0;
      end else if (step) begin
         if (up ? at_top : at_bot) begin
            // Range end: either hold and flag the blocked step, or wrap to the opposite end.
            if (HOLD) begin
               wrap <= 1'b0;
               sat  <= 1'b1;
            end else begin
               q    <= up ? '0 : TOP[WIDTH-1:0];
               wrap <= 1'b1;
               sat  <= 1'b0;
            end
         end else begin
            q    <= up ? q_inc[WIDTH-1:0] : q_dec[WIDTH-1:0];
            wrap <= 1'b0;
            sat  <= 1'b0;
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - self-checking bench for updown_counter (wrap, saturate, prescale instances)
module tb_updown_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;

   logic [3:0] q0, q1, q2;
   logic       tc0, tc1, tc2;
   logic       wrap0, wrap1, wrap2;
   logic       sat0, sat1, sat2;

   always #5 clk = ~clk;

   updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) dut_wrap (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .q(q0), .tc(tc0), .wrap(wrap0), .sat(sat0));

   updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) dut_sat (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .q(q1), .tc(tc1), .wrap(wrap1), .sat(sat1));

   updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) dut_pre (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .q(q2), .tc(tc2), .wrap(wrap2), .sat(sat2));

   typedef struct {
      string      name;
      int         dut;
      logic       rst;
      logic       en;
      logic       up;
      logic       ld;
      logic [3:0] lv;
      logic [3:0] q;
      logic       wrap;
      logic       sat;
      logic       tc;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   checks = 0;
   int   failures = 0;

   function automatic vec_t mk(string name, int dut, logic rst, logic e, logic u, logic ld,
                               logic [3:0] lv, logic [3:0] eq, logic ew, logic es, logic et);
      vec_t v;
      v.name = name; v.dut = dut; v.rst = rst; v.en = e; v.up = u; v.ld = ld; v.lv = lv;
      v.q = eq; v.wrap = ew; v.sat = es; v.tc = et;
      return v;
   endfunction

   task automatic chk(string name, string sig, logic [3:0] act, logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s.%s actual=%0d expected=%0d", name, sig, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
   task automatic apply(vec_t v);
      vec_t e;
      logic [3:0] aq;
      logic aw, as, at;
      reset = v.rst; en = v.en; up = v.up; load = v.ld; load_val = v.lv;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      case (e.dut)
         0:       begin aq = q0; aw = wrap0; as = sat0; at = tc0; end
         1:       begin aq = q1; aw = wrap1; as = sat1; at = tc1; end
         default: begin aq = q2; aw = wrap2; as = sat2; at = tc2; end
      endcase
      chk(e.name, "q",    aq,         e.q);
      chk(e.name, "wrap", {3'b0, aw}, {3'b0, e.wrap});
      chk(e.name, "sat",  {3'b0, as}, {3'b0, e.sat});
      chk(e.name, "tc",   {3'b0, at}, {3'b0, e.tc});
   endtask

   task automatic seq(string name, int dut, logic rst, logic e, logic u, logic ld,
                      logic [3:0] lv, logic [3:0] eq, logic ew, logic es, logic et);
      apply(mk(name, dut, rst, e, u, ld, lv, eq, ew, es, et));
   endtask

   initial begin
      // Wrap instance: up count through the wrap point.
      tbl.push_back(mk("rst_up", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
      for (int i = 1; i <= 12; i++) begin
         logic [3:0] eq;
         eq = 4'(i % 10);
         tbl.push_back(mk($sformatf("up%0d", i), 0, 0, 1, 1, 0, 0, eq, eq == 0, 0, eq == 9));
      end
      // Wrap instance: down count from zero.
      tbl.push_back(mk("rst_dn", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk("dn1", 0, 0, 1, 0, 0, 0, 9, 1, 0, 0));
      tbl.push_back(mk("dn2", 0, 0, 1, 0, 0, 0, 8, 0, 0, 0));
      tbl.push_back(mk("dn3", 0, 0, 1, 0, 0, 0, 7, 0, 0, 0));
      tbl.push_back(mk("hold", 0, 0, 0, 0, 0, 0, 7, 0, 0, 0));
      // Load clamping and load-over-enable priority.
      tbl.push_back(mk("ld13", 0, 0, 1, 1, 1, 13, 9, 0, 0, 1));
      tbl.push_back(mk("ld13_wrap", 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk("ld5", 0, 0, 1, 0, 1, 5, 5, 0, 0, 0));
      tbl.push_back(mk("ld5_dn", 0, 0, 1, 0, 0, 0, 4, 0, 0, 0));
      // Saturating instance.
      tbl.push_back(mk("s_rst", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk("s_ld8", 1, 0, 0, 1, 1, 8, 8, 0, 0, 0));
      tbl.push_back(mk("s_up1", 1, 0, 1, 1, 0, 0, 9, 0, 0, 1));
      tbl.push_back(mk("s_up2", 1, 0, 1, 1, 0, 0, 9, 0, 1, 1));
      tbl.push_back(mk("s_up3", 1, 0, 1, 1, 0, 0, 9, 0, 1, 1));
      tbl.push_back(mk("s_dn", 1, 0, 1, 0, 0, 0, 8, 0, 0, 0));
      tbl.push_back(mk("s_ld0", 1, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk("s_dn0", 1, 0, 1, 0, 0, 0, 0, 0, 1, 1));
      tbl.push_back(mk("s_hold", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      tbl.push_back(mk("s_ld3", 1, 0, 0, 0, 1, 3, 3, 0, 0, 0));
      tbl.push_back(mk("s_ld0b", 1, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk("s_dn0b", 1, 0, 1, 0, 0, 0, 0, 0, 1, 1));
      tbl.push_back(mk("s_rst2", 1, 1, 1, 0, 0, 0, 0, 0, 0, 1));

      @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // Prescale 3: step every third enabled cycle, en gap delays it by exactly two cycles.
      seq("p_rst", 2, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      seq("p_e1",  2, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      seq("p_e2",  2, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      seq("p_e3",  2, 0, 1, 1, 0, 0, 1, 0, 0, 0);
      seq("p_e4",  2, 0, 1, 1, 0, 0, 1, 0, 0, 0);
      seq("p_g1",  2, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      seq("p_g2",  2, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      seq("p_e5",  2, 0, 1, 0, 0, 0, 1, 0, 0, 0);
      seq("p_e6",  2, 0, 1, 0, 0, 0, 0, 0, 0, 1);

      // Load mid-prescale clears the prescaler and does not advance it.
      seq("p_e7",  2, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      seq("p_ld5", 2, 0, 1, 1, 1, 5, 5, 0, 0, 0);
      seq("p_l1",  2, 0, 1, 1, 0, 0, 5, 0, 0, 0);
      seq("p_l2",  2, 0, 1, 1, 0, 0, 5, 0, 0, 0);
      seq("p_l3",  2, 0, 1, 1, 0, 0, 6, 0, 0, 0);

      // Reset at q=6 with prescaler at 2 discards progress.
      seq("r_e1",  2, 0, 1, 1, 0, 0, 6, 0, 0, 0);
      seq("r_e2",  2, 0, 1, 1, 0, 0, 6, 0, 0, 0);
      seq("r_rst", 2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      seq("r_a1",  2, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      seq("r_a2",  2, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      seq("r_a3",  2, 0, 1, 1, 0, 0, 1, 0, 0, 0);

      // Down wrap through the prescaled instance.
      seq("w_rst", 2, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      seq("w_e1",  2, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      seq("w_e2",  2, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      seq("w_e3",  2, 0, 1, 0, 0, 0, 9, 1, 0, 0);
      seq("w_e4",  2, 0, 1, 0, 0, 0, 9, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter MODULUS, default 16: count range 0..MODULUS-1; legal range 1 <= MODULUS <= 2**WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at range ends, 1 = hold at range ends.
REQ-004 Parameter PRESCALE, default 1: number of enabled cycles per count step; legal range >= 1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  count enable; each high cycle advances the prescaler.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement; sampled on each step.
REQ-009 load  input  1  synchronous parallel load.
REQ-010 load_val  input  WIDTH  value to load.
REQ-011 q  output  WIDTH  registered count.
REQ-012 tc  output  1  combinational terminal count: q == MODULUS-1 when up=1, q == 0 when up=0.
REQ-013 wrap  output  1  registered pulse, one cycle, set on the cycle q wraps.
REQ-014 sat  output  1  registered, high while a step is blocked at a range end (SATURATE=1 only).

Function
REQ-015 Priority per edge: reset > load > step > hold.
REQ-016 Step: occurs on an edge where en=1, load=0 and the prescaler is at PRESCALE-1.
REQ-017 Prescaler: counts en-high cycles 0..PRESCALE-1 and then returns to 0; holds when en=0; PRESCALE=1 makes every enabled cycle a step.
REQ-018 Up step below MODULUS-1: q <= q+1. Down step above 0: q <= q-1.
REQ-019 Up step at MODULUS-1, SATURATE=0: q <= 0 and wrap <= 1.
REQ-020 Up step at MODULUS-1, SATURATE=1: q holds, sat <= 1, wrap stays 0.
REQ-021 Down step at 0, SATURATE=0: q <= MODULUS-1 and wrap <= 1.
REQ-022 Down step at 0, SATURATE=1: q holds and sat <= 1.
REQ-023 wrap is 0 on every edge without a wrapping step; back-to-back wraps give consecutive high cycles.
REQ-024 sat clears on the first edge with a non-blocked step, load, or reset; sat holds while en=0 or between prescaler steps.
REQ-025 Load: q <= load_val, clamped to MODULUS-1 if load_val >= MODULUS; prescaler <= 0; wrap <= 0; sat <= 0.
REQ-026 load and en high together: load wins; no step and no prescaler advance that cycle.
REQ-027 Direction change mid-prescale takes effect at the next step; the prescaler is not reset.
REQ-028 MODULUS=1: q is always 0; tc is always 1; each step wraps (SATURATE=0) or saturates (SATURATE=1).
REQ-029 MODULUS = 2**WIDTH: wrap behaviour equals natural modulo-2**WIDTH arithmetic.
REQ-030 All internal arithmetic uses WIDTH+1 bits so there is no overflow at MODULUS = 2**WIDTH.

Reset
REQ-031 On reset: q=0, prescaler=0, wrap=0, sat=0; tc then reflects q=0 and up.
REQ-032 Reset asserted mid-prescale or mid-count discards all progress; counting resumes with the first enabled cycle after reset is released.
REQ-033 Reset has no asynchronous path; outputs change only on clk rising edge.

Structure
REQ-034 The shared package holds the mode constants MODE_WRAP=0 and MODE_SAT=1 and a function that gives the clamped load value.
REQ-035 The prescaler is the single sub-module tick_gen (parameter PRESCALE; ports clk, reset, en, clr, tick).
REQ-036 Illegal parameters (MODULUS < 1, MODULUS > 2**WIDTH, PRESCALE < 1) are rejected at elaboration.

Verification
REQ-037 WIDTH=4, MODULUS=10, PRESCALE=1, up=1, en=1 for 12 cycles after reset -> q = 1..9, 0, 1, 2; wrap high only on the cycle q becomes 0.
REQ-038 Same parameters, up=0 from q=0 -> q = 9, 8, 7; wrap on the first step; tc=1 at q=0.
REQ-039 SATURATE=1, MODULUS=10, load 8, up=1, 3 steps -> q = 9, 9, 9; sat=1 from the second step; then up=0 for 1 step -> q=8, sat=0.
REQ-040 PRESCALE=3, en=1 continuous -> q increments every 3rd cycle; en low for 2 cycles mid-count -> step delayed by exactly 2 cycles.
REQ-041 load=1 with load_val=13 and en=1 (MODULUS=10) -> q=9, no step, prescaler cleared.
REQ-042 Reset pulsed for 1 cycle at q=6 with prescaler at 2 (PRESCALE=3) -> q=0, wrap=0, sat=0; the next step arrives 3 enabled cycles after release.
